nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple_carry adder, one nibble per clock, LSB nibble first. The inter-nibble carry is held in a register. Operands are accepted over a valid/ready start handshake, and the result is returned over a valid/ready done handshake. It sits between a requesting datapath or controller and the shared 4-bit adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.
- NIB, WIDTH/4, number of nibble steps (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  requester presents an operation.
- start_ready  out  1  block can accept an operation.
- op_a  in  WIDTH  operand A; sampled on start handshake.
- op_b  in  WIDTH  operand B; sampled on start handshake.
- sub  in  1  1 computes A−B, 0 computes A+B; sampled on start handshake.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB nibble; for subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- done_valid  out  1  result/cout/ovf valid.
- done_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, result=0, cout=0, ovf=0, done_valid=0, busy=0, nibble index=0, carry register=0. start_ready=1 after reset.
- start_ready = (state==IDLE) and done_valid = (state==DONE). Both are decoded combinationally from state only, with no dependence on the valid inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start_valid && start_ready at an edge, capture op_a into working A.
  - Capture op_b into working B, or ~op_b if sub=1.
  - Set carry register = sub and index = 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - The adder takes A nibble[index], B nibble[index] and the carry register.
  - The sum nibble is stored into the working result at nibble[index], the carry register takes Cout, and index increments.
  - When index==NIB-1 at the edge:
    - Copy the working result to result.
    - Set cout = final Cout.
    - Set ovf = (A[WIDTH-1]==Bw[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]), where Bw is the possibly inverted B.
    - Go to DONE.
- DONE: hold result/cout/ovf stable. On done_ready go to IDLE; otherwise stay.
- Output stability: result, cout and ovf change only on the RUN→DONE edge or on reset. During RUN they hold the previous operation's values.
- Latency: with the start handshake at the edge ending cycle 0, RUN occupies cycles 1..NIB and done_valid is high from cycle NIB+1. For WIDTH=16, that is cycle 5.
- Throughput: one operation per NIB+2 cycles minimum. There is one mandatory IDLE bubble after DONE, and no start is accepted in the same cycle as done acceptance.
- Boundary conditions:
  - start_valid during RUN or DONE is ignored, since start_ready=0.
  - Operand inputs may change freely outside the handshake cycle.
  - done_ready while not in DONE has no effect.
  - The carry must propagate across every nibble boundary, including a full ripple on FFFF+1.
  - The index does not wrap; it resets to 0 on every accept.
  - rst asserted in any state, including mid-RUN, aborts the operation. The next cycle is IDLE with all reset values, and done_valid is never asserted for the aborted operation.
  - rst has priority over every handshake in the same cycle.

Decomposition:
- Shared package/include holds NIB_W=4 and the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module instance: the existing ripple_carry 4-bit adder (S, Cout, A, B, Cin). Nibble select muxes feed it, driven by the index.
- No other hierarchy.

Test Plan:
- Add, 16'h1234+16'h4321 → result=16'h5555, cout=0, ovf=0; done_valid first high exactly 5 cycles after the start edge; start_ready low cycles 1..5.
- Add, 16'hFFFF+16'h0001 → result=16'h0000, cout=1, ovf=0 (carry crosses all 3 nibble boundaries). 16'h7FFF+16'h0001 → 16'h8000, cout=0, ovf=1.
- Subtract: 16'h0005−16'h0007 → 16'hFFFE, cout=0, ovf=0. 16'h8000−16'h0001 → 16'h7FFF, cout=1, ovf=1.
- Backpressure: hold done_ready=0 for 10 cycles in DONE → done_valid stays 1 and result is constant. start_valid=1 with new operands during that time is not accepted. Release done_ready → IDLE next cycle; the new op is accepted one cycle later and completes correctly.
- Mid-operation reset: pulse rst in RUN cycle 2 of 16'hAAAA+16'h5555 → next cycle IDLE, result=0, cout=0, ovf=0, no done_valid pulse. A following 16'h0F0F+16'h00F1 → 16'h1000, cout=0, ovf=0.
- Back-to-back random add/sub, 200 ops with WIDTH=16 and WIDTH=32 → every result/cout/ovf matches the reference model. Spacing is exactly NIB+2 cycles with done_ready tied high.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   NIB_W   : width of the shared adder slice (one nibble)
//   state_t : sequencer state encoding
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_ripple_carry.sv
// 4-bit ripple-carry adder slice shared by the sequencer, one nibble per clock.
// Ports:
//   A, B : nibble operands
//   Cin  : carry in
//   S    : nibble sum
//   Cout : carry out of bit 3
module nibble_serial_add_ctrl_ripple_carry
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] S,
  output logic             Cout
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < NIB_W; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single shared
// 4-bit ripple-carry adder, LSB nibble first, with a registered inter-nibble carry.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start_valid/start_ready  : operation request handshake (op_a, op_b, sub sampled)
//   op_a, op_b, sub          : operands; sub=1 computes op_a - op_b
//   result, cout, ovf        : sum/difference, MSB carry (1 = no borrow), signed overflow
//   done_valid/done_ready    : result handshake
//   busy                     : high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | ready for a new operation (start_ready=1)
// RUN   | one nibble added per cycle, index 0..NIB-1
// DONE  | result presented, waiting for done_ready
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // already inverted for subtract
  logic [WIDTH-1:0]   sum_q, sum_d;  // working result, filled nibble by nibble
  logic [WIDTH-1:0]   result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   add_a, add_b, add_s;
  logic               add_co;

  assign add_a = a_q[idx_q*NIB_W +: NIB_W];
  assign add_b = b_q[idx_q*NIB_W +: NIB_W];

  nibble_serial_add_ctrl_ripple_carry u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          // Subtract as A + ~B + 1: the +1 enters as the initial carry.
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = add_s;
        carry_d = add_co;
        if (idx_q == IDX_W'(NIB - 1)) begin
          // sum_d already holds the final nibble, so the MSB used for ovf is current.
          result_d = sum_d;
          cout_d   = add_co;
          ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int NIB16 = 4;
  localparam int NIB32 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sub = 1'b0;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic        busy;

  logic        start_valid_w = 1'b0;
  logic        start_ready_w;
  logic [31:0] op_a_w = '0;
  logic [31:0] op_b_w = '0;
  logic        sub_w = 1'b0;
  logic [31:0] result_w;
  logic        cout_w;
  logic        ovf_w;
  logic        done_valid_w;
  logic        done_ready_w = 1'b0;
  logic        busy_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .result(result), .cout(cout), .ovf(ovf),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid_w), .start_ready(start_ready_w),
    .op_a(op_a_w), .op_b(op_b_w), .sub(sub_w),
    .result(result_w), .cout(cout_w), .ovf(ovf_w),
    .done_valid(done_valid_w), .done_ready(done_ready_w), .busy(busy_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    // Make the outputs non-trivial first so reset has something to clear.
    rst = 1'b0;
    start_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0;
    step();
    start_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({result, cout, ovf} !== 18'h0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b exp=0000/0/0", result, cout, ovf); end
    total++; if ({start_ready_w, done_valid_w, busy_w} !== 3'b100) begin bad++; $display("FAIL reset_w32_flags got=%b exp=100", {start_ready_w, done_valid_w, busy_w}); end
  endtask

  task automatic test_add_sub();
    logic [15:0] va[5]  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb[5]  = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] er[5]  = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int early;
    for (int v = 0; v < 5; v++) begin
      start_valid = 1'b1; op_a = va[v]; op_b = vb[v]; sub = vs[v];
      step();
      start_valid = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~vs[v];
      early = 0;
      for (int c = 1; c <= NIB16; c++) begin
        if (done_valid !== 1'b0 || start_ready !== 1'b0 || busy !== 1'b1) early++;
        step();
      end
      total++; if (early != 0) begin bad++; $display("FAIL latency_v%0d early_or_ready_cycles=%0d exp=0", v, early); end
      total++; if ({done_valid, start_ready} !== 2'b10) begin bad++; $display("FAIL done_cycle5_v%0d got=%b exp=10", v, {done_valid, start_ready}); end
      total++; if ({result, cout, ovf} !== {er[v], ec[v], eo[v]}) begin
        bad++; $display("FAIL result_v%0d got=%h/%b/%b exp=%h/%b/%b", v, result, cout, ovf, er[v], ec[v], eo[v]);
      end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      total++; if ({start_ready, done_valid} !== 2'b10) begin bad++; $display("FAIL back_to_idle_v%0d got=%b exp=10", v, {start_ready, done_valid}); end
    end
  endtask

  task automatic test_backpressure();
    int held_bad;
    int run_bad;
    start_valid = 1'b1; op_a = 16'h1234; op_b = 16'h4321; sub = 1'b0;
    step();
    start_valid = 1'b0;
    repeat (NIB16) step();
    // In DONE: present a competing request that must be ignored.
    start_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0002; sub = 1'b0;
    held_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if ({done_valid, start_ready, result} !== {2'b10, 16'h5555}) held_bad++;
      step();
    end
    total++; if (held_bad != 0) begin bad++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0", held_bad); end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    total++; if ({start_ready, done_valid, busy} !== 3'b100) begin bad++; $display("FAIL release_idle got=%b exp=100", {start_ready, done_valid, busy}); end
    step();
    start_valid = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF;
    total++; if ({busy, start_ready} !== 2'b10) begin bad++; $display("FAIL late_accept got=%b exp=10", {busy, start_ready}); end
    run_bad = 0;
    for (int c = 1; c <= NIB16; c++) begin
      if (result !== 16'h5555) run_bad++;
      step();
    end
    total++; if (run_bad != 0) begin bad++; $display("FAIL result_stable_in_run bad_cycles=%0d exp=0", run_bad); end
    total++; if ({done_valid, result, cout, ovf} !== {1'b1, 16'h0003, 2'b00}) begin
      bad++; $display("FAIL backpressure_new_op got=%b/%h/%b/%b exp=1/0003/0/0", done_valid, result, cout, ovf);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int dv_seen;
    start_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b0;
    step();
    start_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({start_ready, busy, done_valid} !== 3'b100) begin bad++; $display("FAIL abort_state got=%b exp=100", {start_ready, busy, done_valid}); end
    total++; if ({result, cout, ovf} !== 18'h0) begin bad++; $display("FAIL abort_outputs got=%h/%b/%b exp=0000/0/0", result, cout, ovf); end
    dv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_valid !== 1'b0) dv_seen++;
      step();
    end
    total++; if (dv_seen != 0) begin bad++; $display("FAIL abort_no_done cycles=%0d exp=0", dv_seen); end
    start_valid = 1'b1; op_a = 16'h0F0F; op_b = 16'h00F1; sub = 1'b0;
    step();
    start_valid = 1'b0;
    repeat (NIB16) step();
    total++; if ({done_valid, result, cout, ovf} !== {1'b1, 16'h1000, 2'b00}) begin
      bad++; $display("FAIL after_abort_op got=%b/%h/%b/%b exp=1/1000/0/0", done_valid, result, cout, ovf);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_back_to_back_16();
    logic [15:0] a, b, bw;
    logic        s, eovf;
    logic [16:0] full;
    int early;
    done_ready = 1'b1;
    start_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
      op_a = a; op_b = b; sub = s;
      total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL b2b16_spacing op=%0d start_ready=%b exp=1", n, start_ready); end
      step();
      bw   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bw} + 17'(s);
      eovf = (a[15] == bw[15]) && (full[15] != a[15]);
      early = 0;
      for (int c = 1; c <= NIB16; c++) begin
        if (done_valid !== 1'b0) early++;
        op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom_range(0, 1));
        step();
      end
      total++; if (early != 0 || done_valid !== 1'b1) begin bad++; $display("FAIL b2b16_latency op=%0d early=%0d done_valid=%b", n, early, done_valid); end
      total++; if ({result, cout, ovf} !== {full[15:0], full[16], eovf}) begin
        bad++; $display("FAIL b2b16_result op=%0d a=%h b=%h sub=%b got=%h/%b/%b exp=%h/%b/%b", n, a, b, s, result, cout, ovf, full[15:0], full[16], eovf);
      end
      step();
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
  endtask

  task automatic test_back_to_back_32();
    logic [31:0] a, b, bw;
    logic        s, eovf;
    logic [32:0] full;
    int early;
    done_ready_w = 1'b1;
    start_valid_w = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (n == 0) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; s = 1'b0; end
      op_a_w = a; op_b_w = b; sub_w = s;
      total++; if (start_ready_w !== 1'b1) begin bad++; $display("FAIL b2b32_spacing op=%0d start_ready=%b exp=1", n, start_ready_w); end
      step();
      bw   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bw} + 33'(s);
      eovf = (a[31] == bw[31]) && (full[31] != a[31]);
      early = 0;
      for (int c = 1; c <= NIB32; c++) begin
        if (done_valid_w !== 1'b0) early++;
        op_a_w = $urandom; op_b_w = $urandom; sub_w = 1'($urandom_range(0, 1));
        step();
      end
      total++; if (early != 0 || done_valid_w !== 1'b1) begin bad++; $display("FAIL b2b32_latency op=%0d early=%0d done_valid=%b", n, early, done_valid_w); end
      total++; if ({result_w, cout_w, ovf_w} !== {full[31:0], full[32], eovf}) begin
        bad++; $display("FAIL b2b32_result op=%0d a=%h b=%h sub=%b got=%h/%b/%b exp=%h/%b/%b", n, a, b, s, result_w, cout_w, ovf_w, full[31:0], full[32], eovf);
      end
      step();
    end
    start_valid_w = 1'b0;
    done_ready_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_mid_reset();
    test_back_to_back_16();
    test_back_to_back_32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
